// File: rtl/obj_list_if.sv
// Handshake bundle between obj_list and its spawner/updater: append port,
// walk port and the status outputs.
interface obj_list_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  logic              insert_en;
  logic [DATA_W-1:0] insert_data;
  logic              insert_ready;
  logic              iter_start;
  logic              iter_done;
  logic              iter_valid;
  logic [CNT_W-1:0]  iter_index;
  logic [DATA_W-1:0] iter_out;
  logic [DATA_W-1:0] iter_in;
  logic              iter_remove;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output insert_en, insert_data, iter_start, iter_in, iter_remove,
    input  insert_ready, iter_done, iter_valid, iter_index, iter_out, count, overflow
  );

  modport slave (
    input  insert_en, insert_data, iter_start, iter_in, iter_remove,
    output insert_ready, iter_done, iter_valid, iter_index, iter_out, count, overflow
  );
endinterface

// File: rtl/obj_list.sv
// Compacting object list: appends in IDLE, and during a walk rewrites or drops
// each element, packing survivors down to indices 0..count-1.
module obj_list #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     ce,
  input  logic     clear,
  obj_list_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic {IDLE, ITER} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  count, count_nx;
  logic [CNT_W-1:0]  r, r_nx, w, w_nx, n, n_nx;
  logic              overflow, overflow_nx;
  logic              we;
  logic [AW-1:0]     waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_nx    = state;
    count_nx    = count;
    overflow_nx = overflow;
    r_nx        = r;
    w_nx        = w;
    n_nx        = n;
    we          = 1'b0;
    waddr       = count[AW-1:0];
    wdata       = bus.insert_data;

    bus.insert_ready = (state == IDLE) && (count < DEPTH_C) && !bus.iter_start && !clear;
    bus.iter_done    = (state == IDLE);
    bus.iter_valid   = (state == ITER);
    bus.iter_index   = (state == ITER) ? r : '0;
    bus.iter_out     = mem[r[AW-1:0]];
    bus.count        = count;
    bus.overflow     = overflow;

    if (ce) begin
      if (clear) begin
        count_nx    = '0;
        overflow_nx = 1'b0;
        state_nx    = IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.iter_start) begin
              if (count != '0) begin
                n_nx     = count;
                r_nx     = '0;
                w_nx     = '0;
                state_nx = ITER;
              end
            end else if (bus.insert_en) begin
              if (count < DEPTH_C) begin
                we       = 1'b1;
                count_nx = count + ONE;
              end else begin
                overflow_nx = 1'b1;
              end
            end
          end
          ITER: begin
            // Write pointer never passes the read pointer, so compaction is in place.
            if (!bus.iter_remove) begin
              we    = 1'b1;
              waddr = w[AW-1:0];
              wdata = bus.iter_in;
              w_nx  = w + ONE;
            end
            r_nx = r + ONE;
            if (r == n - ONE) begin
              count_nx = w + {{(CNT_W-1){1'b0}}, !bus.iter_remove};
              state_nx = IDLE;
            end
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      count    <= '0;
      overflow <= 1'b0;
      r        <= '0;
      w        <= '0;
      n        <= '0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      overflow <= overflow_nx;
      r        <= r_nx;
      w        <= w_nx;
      n        <= n_nx;
    end
  end

  // NOTE: the storage array has no reset; only indices below count are ever read as live.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
endmodule

// File: tb/tb_obj_list.sv
// Self-checking bench for obj_list (DEPTH=4): directed plan steps plus random
// inserts/walks/clears against a queue-based model of the list.
module tb_obj_list;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce = 1'b0;
  logic clear = 1'b0;

  obj_list_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  obj_list #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .ce(ce), .clear(clear), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic [DATA_W-1:0] model[$];
  bit m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic ins(input logic [DATA_W-1:0] d);
    bit room;
    align();
    room = (model.size() < DEPTH);
    ce = 1'b1; bus.insert_en = 1'b1; bus.insert_data = d;
    @(negedge clk); check("ins_ready", 32'(bus.insert_ready), 32'(room));
    @(posedge clk); #1; bus.insert_en = 1'b0;
    if (room) model.push_back(d); else m_ovf = 1'b1;
    @(negedge clk);
    check("ins_count", 32'(bus.count), 32'(model.size()));
    check("ins_ovf", 32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic do_clear();
    align();
    ce = 1'b1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    model.delete(); m_ovf = 1'b0;
    @(negedge clk);
    check("clr_count", 32'(bus.count), 0);
    check("clr_ovf", 32'(bus.overflow), 0);
    check("clr_done", 32'(bus.iter_done), 1);
  endtask

  // Walk: element j is dropped when rm_mask[j], otherwise rewritten as value+add.
  task automatic walk(input logic [3:0] rm_mask, input logic [DATA_W-1:0] add, input int stall_at);
    int n;
    logic [DATA_W-1:0] nxt[$];
    align();
    n = model.size();
    ce = 1'b1; bus.iter_start = 1'b1; bus.insert_en = 1'b1; bus.insert_data = 16'hdead;
    @(negedge clk); check("walk_start_rdy", 32'(bus.insert_ready), 0);
    @(posedge clk); #1; bus.iter_start = 1'b0;
    if (n == 0) begin
      bus.insert_en = 1'b0;
      repeat (3) begin
        @(negedge clk);
        check("empty_done", 32'(bus.iter_done), 1);
        check("empty_valid", 32'(bus.iter_valid), 0);
      end
      return;
    end
    for (int j = 0; j < n; j++) begin
      if (j == stall_at) begin
        ce = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_index", 32'(bus.iter_index), 32'(j));
          check("stall_out", 32'(bus.iter_out), 32'(model[j]));
          @(posedge clk); #1;
        end
        ce = 1'b1;
      end
      bus.iter_remove = rm_mask[j];
      bus.iter_in = model[j] + add;
      @(negedge clk);
      check("walk_valid", 32'(bus.iter_valid), 1);
      check("walk_done", 32'(bus.iter_done), 0);
      check("walk_index", 32'(bus.iter_index), 32'(j));
      check("walk_out", 32'(bus.iter_out), 32'(model[j]));
      if (!rm_mask[j]) nxt.push_back(model[j] + add);
      @(posedge clk); #1;
    end
    bus.insert_en = 1'b0; bus.iter_remove = 1'b0;
    model = nxt;
    @(negedge clk);
    check("walk_end_done", 32'(bus.iter_done), 1);
    check("walk_end_valid", 32'(bus.iter_valid), 0);
    check("walk_end_count", 32'(bus.count), 32'(model.size()));
    check("walk_end_ovf", 32'(bus.overflow), 32'(m_ovf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    logic [DATA_W-1:0] v;
    bus.insert_en = 1'b0; bus.insert_data = '0; bus.iter_start = 1'b0;
    bus.iter_in = '0; bus.iter_remove = 1'b0;

    #12;
    check("rst_done", 32'(bus.iter_done), 1);
    check("rst_valid", 32'(bus.iter_valid), 0);
    check("rst_index", 32'(bus.iter_index), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_ready", 32'(bus.insert_ready), 1);
    rst = 1'b1;

    for (int i = 1; i <= 4; i++) ins(16'(i));
    walk(4'b0000, 16'd0, 99);
    repeat (4) walk(4'b0000, 16'd1, 99);
    walk(4'b0101, 16'd0, 99);
    walk(4'b0000, 16'd0, 99);

    ins(16'h0a); ins(16'h0b); ins(16'h0c);
    do_clear();
    walk(4'b0000, 16'd0, 99);

    for (int i = 0; i < 4; i++) ins(16'(16'h20 + i));
    walk(4'b0000, 16'h10, 1);
    walk(4'b0000, 16'd0, 99);

    align();
    ce = 1'b1; bus.iter_start = 1'b1;
    @(posedge clk); #1; bus.iter_start = 1'b0; bus.iter_in = model[0]; bus.iter_remove = 1'b0;
    @(posedge clk); #1; bus.iter_in = model[1];
    @(negedge clk);
    check("pre_rst_index", 32'(bus.iter_index), 1);
    rst = 1'b0;
    #1;
    check("arst_done", 32'(bus.iter_done), 1);
    check("arst_count", 32'(bus.count), 0);
    check("arst_valid", 32'(bus.iter_valid), 0);
    check("arst_index", 32'(bus.iter_index), 0);
    check("arst_ready", 32'(bus.insert_ready), 1);
    #2; rst = 1'b1;
    model.delete(); m_ovf = 1'b0;
    ins(16'h9);
    walk(4'b0000, 16'd0, 99);

    ins(16'h31); ins(16'h32);
    align();
    bus.iter_start = 1'b1;
    @(posedge clk); #1; bus.iter_start = 1'b0; bus.iter_in = model[0];
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    model.delete();
    @(negedge clk);
    check("midclr_done", 32'(bus.iter_done), 1);
    check("midclr_count", 32'(bus.count), 0);
    check("midclr_valid", 32'(bus.iter_valid), 0);

    for (int i = 0; i < 60; i++) begin
      op = int'($urandom_range(0, 9));
      if (op <= 4) begin
        ins(16'($urandom));
      end else if (op <= 7) begin
        walk(4'($urandom_range(0, 15)), 16'($urandom), int'($urandom_range(0, 6)));
      end else if (op == 8) begin
        do_clear();
      end else begin
        align();
        v = 16'($urandom);
        ce = 1'b0; bus.insert_en = 1'b1; bus.insert_data = v; bus.iter_start = 1'b1;
        @(posedge clk); #1;
        bus.insert_en = 1'b0; bus.iter_start = 1'b0; ce = 1'b1;
        @(negedge clk);
        check("ce_low_count", 32'(bus.count), 32'(model.size()));
        check("ce_low_done", 32'(bus.iter_done), 1);
      end
    end
    walk(4'b0000, 16'd0, 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
